fifo_drain_arbiter: RTL and testbench

Round-robin drain scheduler for the two ingress FIFOs of the data-flow stage. It decides which FIFO is popped each cycle and bounds each turn to a fixed burst length. It honours a downstream pause, and merges both FIFO outputs onto one registered output lane tagged with its source. It sits between the FIFO pair and the next switching stage, replacing independent per-FIFO read enables with a single arbitrated read sequence.

---
 rtl/fifo_drain_arbiter_pkg.sv | 13 +
 rtl/fifo_drain_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_drain_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and constants for the two-FIFO drain arbiter.
package fifo_drain_arbiter_pkg;

   localparam int unsigned DataWDef = 10;
   localparam int unsigned CntW     = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StServe0 = 2'd1,
      StServe1 = 2'd2
   } state_e;

endpackage

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain scheduler for two ingress FIFOs with a bounded burst per turn,
// downstream pause, and a registered merged output lane tagged with its source.
module fifo_drain_arbiter
   import fifo_drain_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W    = DataWDef,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty0,
   input  logic              fifo_empty1,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   input  logic              pause,
   output logic              pop0,
   output logic              pop1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              src_out,
   output logic              busy
);

   localparam logic [CntW-1:0] BurstMax = CntW'(BURST_LEN);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rr_q, rr_d;     // next preferred FIFO when both have data
   logic            pop_q, src_q;   // pop issued last cycle, and which FIFO
   logic            pop0_c, pop1_c;

   // Arbitration state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
      end
   end

   // Next-state, burst counting and pop strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      pop0_c  = 1'b0;
      pop1_c  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!pause) begin
               if (!fifo_empty0 && !fifo_empty1) begin
                  state_d = rr_q ? StServe1 : StServe0;
               end else if (!fifo_empty0) begin
                  state_d = StServe0;
               end else if (!fifo_empty1) begin
                  state_d = StServe1;
               end
               cnt_d = '0;
            end
         end
         StServe0: begin
            pop0_c = !fifo_empty0 && !pause && (cnt_q < BurstMax);
            if (pop0_c) cnt_d = cnt_q + CntW'(1);
            // Turn ends on the edge of the last pop so the other FIFO pops next cycle.
            if (fifo_empty0 || cnt_d == BurstMax) begin
               rr_d    = 1'b1;
               cnt_d   = '0;
               state_d = fifo_empty1 ? StIdle : StServe1;
            end
         end
         StServe1: begin
            pop1_c = !fifo_empty1 && !pause && (cnt_q < BurstMax);
            if (pop1_c) cnt_d = cnt_q + CntW'(1);
            if (fifo_empty1 || cnt_d == BurstMax) begin
               rr_d    = 1'b0;
               cnt_d   = '0;
               state_d = fifo_empty0 ? StIdle : StServe0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobes are held low for the whole reset assertion, not just after the edge.
   assign pop0 = pop0_c & ~reset;
   assign pop1 = pop1_c & ~reset;
   assign busy = (state_q != StIdle);

   // Output lane: FIFO data arrives one cycle after the pop and is registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pop_q     <= 1'b0;
         src_q     <= 1'b0;
         data_out  <= '0;
         valid_out <= 1'b0;
         src_out   <= 1'b0;
      end else begin
         pop_q     <= pop0 | pop1;
         src_q     <= pop1;
         valid_out <= pop_q;
         if (pop_q) begin
            data_out <= src_q ? data_in1 : data_in0;
            src_out  <= src_q;
         end
      end
   end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: acts as the FIFO pair, keeps a behavioural model of the
// drain schedule, and compares every DUT output on every cycle.
module tb_fifo_drain_arbiter;

   localparam int DW = 10;
   localparam int BL = 4;

   logic          clk, reset, fifo_empty0, fifo_empty1, pause;
   logic [DW-1:0] data_in0, data_in1, data_out;
   logic          pop0, pop1, valid_out, src_out, busy;

   fifo_drain_arbiter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty0(fifo_empty0),
      .fifo_empty1(fifo_empty1),
      .data_in0   (data_in0),
      .data_in1   (data_in1),
      .pause      (pause),
      .pop0       (pop0),
      .pop1       (pop1),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .src_out    (src_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // FIFO contents as seen by the DUT
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   // Model: whose turn it is (-1 none), pops taken this turn, preferred FIFO
   int            m_turn, m_cnt, m_rr;
   // Model output lane: one in-flight stage plus the registered outputs
   bit            pd_pop, pd_src;
   logic [DW-1:0] pd_data;
   bit            m_valid, m_src;
   logic [DW-1:0] m_dout;

   // Last sampled DUT outputs, for the directed pattern checks
   bit            s_pop0, s_pop1, s_valid, s_busy;
   logic [DW-1:0] s_dout;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void set_flags();
      fifo_empty0 = (q0.size() == 0);
      fifo_empty1 = (q1.size() == 0);
   endfunction

   function automatic void model_clear();
      m_turn  = -1;
      m_cnt   = 0;
      m_rr    = 0;
      pd_pop  = 0;
      pd_src  = 0;
      pd_data = '0;
      m_valid = 0;
      m_src   = 0;
      m_dout  = '0;
   endfunction

   // One clock cycle: compare at the falling edge, then advance FIFOs and model.
   task automatic step(input bit nxt_pause, input bit rnd);
      bit            e0, e1, p, x0, x1;
      int            other;
      logic [DW-1:0] w;
      @(negedge clk);
      e0 = fifo_empty0;
      e1 = fifo_empty1;
      p  = pause;
      x0 = (m_turn == 0) && !e0 && !p && (m_cnt < BL);
      x1 = (m_turn == 1) && !e1 && !p && (m_cnt < BL);
      chk("pop0", pop0, x0);
      chk("pop1", pop1, x1);
      chk("busy", busy, m_turn >= 0);
      chk("valid_out", valid_out, m_valid);
      chk("src_out", src_out, m_src);
      chk("data_out", data_out, m_dout);
      s_pop0  = pop0;
      s_pop1  = pop1;
      s_valid = valid_out;
      s_busy  = busy;
      s_dout  = data_out;
      w = x0 ? q0[0] : (x1 ? q1[0] : '0);
      @(posedge clk);
      #1;
      m_valid = pd_pop;
      if (pd_pop) begin
         m_dout = pd_data;
         m_src  = pd_src;
      end
      pd_pop  = x0 | x1;
      pd_data = w;
      pd_src  = x1;
      if (x0) data_in0 = q0.pop_front();
      if (x1) data_in1 = q1.pop_front();
      if (m_turn < 0) begin
         if (!p) begin
            if (!e0 && !e1) m_turn = m_rr;
            else if (!e0)   m_turn = 0;
            else if (!e1)   m_turn = 1;
            m_cnt = 0;
         end
      end else begin
         if (x0 || x1) m_cnt++;
         if ((m_turn == 0 ? e0 : e1) || m_cnt == BL) begin
            other  = 1 - m_turn;
            m_rr   = other;
            m_turn = ((other == 0) ? !e0 : !e1) ? other : -1;
            m_cnt  = 0;
         end
      end
      if (rnd) begin
         if (q0.size() < 12 && $urandom_range(0, 1) == 1) q0.push_back(DW'($urandom));
         if (q1.size() < 12 && $urandom_range(0, 1) == 1) q1.push_back(DW'($urandom));
         pause = ($urandom_range(0, 4) == 0);
      end else begin
         pause = nxt_pause;
      end
      set_flags();
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset(input bit clear);
      reset = 1'b1;
      #1;
      chk("rst_pop0", pop0, 0);
      chk("rst_pop1", pop1, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_src", src_out, 0);
      chk("rst_busy", busy, 0);
      model_clear();
      if (clear) begin
         q0.delete();
         q1.delete();
      end
      pause = 1'b0;
      set_flags();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [23:0]   v0, v1, vv, vb;
      logic [DW-1:0] outs[$];

      reset    = 1'b1;
      pause    = 1'b0;
      data_in0 = '0;
      data_in1 = '0;
      set_flags();
      model_clear();
      #2;
      do_reset(1);

      // Three words in FIFO 0 only
      do_reset(1);
      q0.push_back(10'h2A5);
      q0.push_back(10'h15A);
      q0.push_back(10'h0C3);
      set_flags();
      v0 = '0; vv = '0; vb = '0;
      outs.delete();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0);
         v0[i] = s_pop0;
         vv[i] = s_valid;
         vb[i] = s_busy;
         if (s_valid) outs.push_back(s_dout);
      end
      chk("s1_pop0", v0, 24'h00000E);
      chk("s1_valid", vv, 24'h000038);
      chk("s1_busy", vb, 24'h00001E);
      chk("s1_nout", outs.size(), 3);
      if (outs.size() == 3) begin
         chk("s1_A", outs[0], 10'h2A5);
         chk("s1_B", outs[1], 10'h15A);
         chk("s1_C", outs[2], 10'h0C3);
      end

      // Ten words in each FIFO, bursts of four
      do_reset(1);
      for (int i = 0; i < 10; i++) begin
         q0.push_back(DW'(i));
         q1.push_back(DW'(i + 'h100));
      end
      set_flags();
      v0 = '0; v1 = '0;
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 1'b0);
         v0[i] = s_pop0;
         v1[i] = s_pop1;
      end
      chk("s2_pop0", v0, 24'h061E1E);
      chk("s2_pop1", v1, 24'h31E1E0);

      // Pause for three cycles after two FIFO 0 pops
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
         q0.push_back(DW'(i + 'h40));
         q1.push_back(DW'(i + 'h80));
      end
      set_flags();
      v0 = '0; v1 = '0; vv = '0;
      for (int i = 0; i < 12; i++) begin
         step((i + 1 >= 3) && (i + 1 <= 5), 1'b0);
         v0[i] = s_pop0;
         v1[i] = s_pop1;
         vv[i] = s_valid;
      end
      chk("s3_pop0", v0, 24'h0000C6);
      chk("s3_pop1", v1, 24'h000F00);
      chk("s3_valid", vv, 24'h000F18);

      // FIFO 1 empties after one pop while FIFO 0 has data; preference then moves to 1
      do_reset(1);
      q1.push_back(10'h3F0);
      set_flags();
      v0 = '0; v1 = '0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         v0[i] = s_pop0;
         v1[i] = s_pop1;
         if (i == 0) begin
            q0.push_back(10'h011);
            q0.push_back(10'h022);
            q0.push_back(10'h033);
            set_flags();
         end
         if (i == 6) begin
            q0.push_back(10'h044);
            q1.push_back(10'h355);
            set_flags();
         end
      end
      chk("s4_pop0", v0, 24'h000038);
      chk("s4_pop1", v1, 24'h000102);

      // Reset during a FIFO 1 burst; afterwards FIFO 0 is preferred again
      do_reset(1);
      q0.push_back(10'h0AA);
      for (int i = 0; i < 6; i++) q1.push_back(DW'(i + 'h2C0));
      set_flags();
      v0 = '0; v1 = '0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         v0[i] = s_pop0;
         v1[i] = s_pop1;
      end
      chk("s5_pre_pop0", v0, 24'h000002);
      chk("s5_pre_pop1", v1, 24'h000018);
      chk("s5_pre_valid", valid_out, 1);
      do_reset(0);
      q0.push_back(10'h1B1);
      q0.push_back(10'h1B2);
      set_flags();
      v0 = '0; v1 = '0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0);
         v0[i] = s_pop0;
         v1[i] = s_pop1;
      end
      chk("s5_post_pop0", v0, 24'h000006);
      chk("s5_post_pop1", v1, 24'h000000);

      // Random traffic, pause and occasional reset against the model
      do_reset(1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset(1);
         step(1'b0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
